// File: rtl/dm_write_trace_if.sv
// Bundle of the data-memory write port, the dump request and the trace drain stream.
// The slave modport is the tracer's view; the master modport is the processor/host view.
interface dm_write_trace_if #(
  parameter int N  = 64,
  parameter int CW = 32
);
  logic          DM_writeEnable;
  logic [N-1:0]  DM_addr;
  logic [N-1:0]  DM_writeData;
  logic          dump;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_addr;
  logic [N-1:0]  out_data;
  logic [CW-1:0] out_seq;
  logic          overflow;
  logic [CW-1:0] total_stores;
  logic          dump_done;

  modport slave (
    input  DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
    output out_valid, out_addr, out_data, out_seq, overflow, total_stores, dump_done
  );

  modport master (
    output DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
    input  out_valid, out_addr, out_data, out_seq, overflow, total_stores, dump_done
  );
endinterface

// File: rtl/dm_write_trace.sv
// Records data-memory stores in program order, then drains them over a valid/ready
// stream once dump is seen. Capture and drain are exclusive, so the FIFO never pushes and pops together.
module dm_write_trace #(
  parameter int N     = 64,
  parameter int DEPTH = 16,
  parameter int CW    = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  dm_write_trace_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);

  typedef struct packed {
    logic [N-1:0]  addr;
    logic [N-1:0]  data;
    logic [CW-1:0] seq;
  } entry_t;

  typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

  state_t        state;
  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        new_e;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count;
  logic          out_valid_q, overflow_q, dump_done_q;
  logic [CW-1:0] total_q;
  logic          push, pop;

  assign new_e  = '{addr: bus.DM_addr, data: bus.DM_writeData, seq: total_q};
  assign push   = (state == CAPTURE) && bus.DM_writeEnable && (count != FULL);
  assign pop    = (state == DRAIN) && out_valid_q && bus.out_ready;
  assign rd_nxt = rd_ptr + AW'(1);

  // Storage carries no reset; the head register below hides it from the outputs.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= new_e;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= CAPTURE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      total_q     <= '0;
      dump_done_q <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (bus.DM_writeEnable) begin
            total_q <= total_q + CW'(1);
            if (count == FULL) overflow_q <= 1'b1;
            else begin
              wr_ptr <= wr_ptr + AW'(1);
              count  <= count + ONE_C;
            end
          end
          // Preload the head so out_valid rises the cycle right after dump is sampled;
          // an empty FIFO with a same-edge store presents that store directly.
          if (bus.dump) begin
            state <= DRAIN;
            if (count != '0) begin
              out_valid_q <= 1'b1;
              head_q      <= mem[rd_ptr];
            end else if (bus.DM_writeEnable) begin
              out_valid_q <= 1'b1;
              head_q      <= new_e;
            end
          end
        end
        DRAIN: begin
          if (pop) begin
            rd_ptr <= rd_nxt;
            count  <= count - ONE_C;
            if (count > ONE_C) head_q <= mem[rd_nxt];
            else begin
              out_valid_q <= 1'b0;
              state       <= DONE;
              dump_done_q <= 1'b1;
            end
          end else if (count == '0) begin
            state       <= DONE;
            dump_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_addr     = head_q.addr;
  assign bus.out_data     = head_q.data;
  assign bus.out_seq      = head_q.seq;
  assign bus.overflow     = overflow_q;
  assign bus.total_stores = total_q;
  assign bus.dump_done    = dump_done_q;
endmodule

// File: tb/tb_dm_write_trace.sv
// Directed bench for dm_write_trace: a vector table for the basic capture/drain flow,
// plus hand-written sequences for overflow, empty dump, back-pressure, same-edge store and mid-drain reset.
module tb_dm_write_trace;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #10 clk = ~clk;

  dm_write_trace_if #(.N(64), .CW(32)) bus ();

  dm_write_trace #(.N(64), .DEPTH(16), .CW(32)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic        dump;
    logic        ready;
    logic        exp_valid;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
    logic [31:0] exp_seq;
    logic        exp_done;
    logic [31:0] exp_total;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [63:0] a, input logic [63:0] d,
                       input logic dmp, input logic rdy);
    bus.DM_writeEnable = we;
    bus.DM_addr        = a;
    bus.DM_writeData   = d;
    bus.dump           = dmp;
    bus.out_ready      = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].dump, vecs[i].ready);
      tick();
      chk($sformatf("%s_valid[%0d]", tag, i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("%s_done[%0d]", tag, i), 64'(bus.dump_done), 64'(vecs[i].exp_done));
      chk($sformatf("%s_total[%0d]", tag, i), 64'(bus.total_stores), 64'(vecs[i].exp_total));
      chk($sformatf("%s_ovf[%0d]", tag, i), 64'(bus.overflow), 64'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid) begin
        chk($sformatf("%s_addr[%0d]", tag, i), bus.out_addr, vecs[i].exp_addr);
        chk($sformatf("%s_data[%0d]", tag, i), bus.out_data, vecs[i].exp_data);
        chk($sformatf("%s_seq[%0d]", tag, i), 64'(bus.out_seq), 64'(vecs[i].exp_seq));
      end
    end
  endtask

  initial begin
    int got;
    logic        hold;
    logic [63:0] h_addr, h_data;
    logic [31:0] h_seq;
    logic        rdy_pat [7];

    //          we addr   data   dump rdy  val eaddr  edata  seq done tot ovf
    vecs[0] = '{1'b1, 64'h00, 64'h11, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0,  0, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b1, 64'h08, 64'h22, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0,  0, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b1, 64'h10, 64'h33, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0,  0, 1'b0, 3, 1'b0};
    vecs[3] = '{1'b0, 64'h00, 64'h00, 1'b1, 1'b1, 1'b1, 64'h00, 64'h11, 0, 1'b0, 3, 1'b0};
    vecs[4] = '{1'b0, 64'h00, 64'h00, 1'b0, 1'b1, 1'b1, 64'h08, 64'h22, 1, 1'b0, 3, 1'b0};
    vecs[5] = '{1'b0, 64'h00, 64'h00, 1'b0, 1'b1, 1'b1, 64'h10, 64'h33, 2, 1'b0, 3, 1'b0};
    vecs[6] = '{1'b0, 64'h00, 64'h00, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0,  0, 1'b1, 3, 1'b0};
    vecs[7] = '{1'b1, 64'h40, 64'h99, 1'b1, 1'b1, 1'b0, 64'h0,  64'h0,  0, 1'b1, 3, 1'b0};

    // Reset values
    do_reset();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ovf",   64'(bus.overflow), 64'd0);
    chk("rst_total", 64'(bus.total_stores), 64'd0);
    chk("rst_done",  64'(bus.dump_done), 64'd0);
    chk("rst_addr",  bus.out_addr, 64'd0);
    chk("rst_data",  bus.out_data, 64'd0);
    chk("rst_seq",   64'(bus.out_seq), 64'd0);

    // Scenario 1: three stores then dump
    run_table("s1");

    // Scenario 2: overflow keeps the oldest 16
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'(i * 8), 64'(i), 1'b0, 1'b0);
      tick();
    end
    chk("s2_ovf_pre", 64'(bus.overflow), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    got = 0;
    for (int c = 0; c < 40 && !bus.dump_done; c++) begin
      if (bus.out_valid) begin
        chk($sformatf("s2_data[%0d]", got), bus.out_data, 64'(got));
        chk($sformatf("s2_addr[%0d]", got), bus.out_addr, 64'(got * 8));
        chk($sformatf("s2_seq[%0d]", got), 64'(bus.out_seq), 64'(got));
        got++;
      end
      tick();
    end
    chk("s2_count", 64'(got), 64'd16);
    chk("s2_done",  64'(bus.dump_done), 64'd1);
    chk("s2_ovf",   64'(bus.overflow), 64'd1);
    chk("s2_total", 64'(bus.total_stores), 64'd20);

    // Scenario 3: dump with nothing recorded
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    chk("s3_valid0", 64'(bus.out_valid), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("s3_valid1", 64'(bus.out_valid), 64'd0);
    chk("s3_done",   64'(bus.dump_done), 64'd1);
    chk("s3_total",  64'(bus.total_stores), 64'd0);

    // Scenario 4: back-pressure while stores keep arriving
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h100 + 64'(i * 8), 64'hA0 + 64'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    got  = 0;
    hold = 1'b0;
    h_addr = '0; h_data = '0; h_seq = '0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 64'h900 + 64'(c), 64'hDEAD + 64'(c), 1'b0, (c < 7) ? rdy_pat[c] : 1'b1);
      if (hold) begin
        chk($sformatf("s4_hold_addr[%0d]", c), bus.out_addr, h_addr);
        chk($sformatf("s4_hold_data[%0d]", c), bus.out_data, h_data);
        chk($sformatf("s4_hold_seq[%0d]", c), 64'(bus.out_seq), 64'(h_seq));
      end
      hold = bus.out_valid && !bus.out_ready;
      h_addr = bus.out_addr; h_data = bus.out_data; h_seq = bus.out_seq;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("s4_addr[%0d]", got), bus.out_addr, 64'h100 + 64'(got * 8));
        chk($sformatf("s4_data[%0d]", got), bus.out_data, 64'hA0 + 64'(got));
        chk($sformatf("s4_seq[%0d]", got), 64'(bus.out_seq), 64'(got));
        got++;
      end
      tick();
    end
    chk("s4_count", 64'(got), 64'd4);
    chk("s4_total", 64'(bus.total_stores), 64'd4);
    chk("s4_done",  64'(bus.dump_done), 64'd1);

    // Scenario 5: store on the same edge as dump is the last entry
    do_reset();
    drive(1'b1, 64'h00, 64'h01, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h08, 64'h02, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h18, 64'hAB, 1'b1, 1'b0); tick();
    chk("s5_valid", 64'(bus.out_valid), 64'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    got = 0;
    h_addr = '0; h_data = '0; h_seq = '0;
    for (int c = 0; c < 10 && !bus.dump_done; c++) begin
      if (bus.out_valid) begin
        h_addr = bus.out_addr; h_data = bus.out_data; h_seq = bus.out_seq;
        got++;
      end
      tick();
    end
    chk("s5_count", 64'(got), 64'd3);
    chk("s5_last_addr", h_addr, 64'h18);
    chk("s5_last_data", h_data, 64'hAB);
    chk("s5_last_seq", 64'(h_seq), 64'd2);
    chk("s5_total", 64'(bus.total_stores), 64'd3);

    // Scenario 6: reset in the middle of a drain, then a clean rerun
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'(i * 8), 64'h50 + 64'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick(); tick();
    chk("s6_mid_valid", 64'(bus.out_valid), 64'd1);
    chk("s6_mid_data", bus.out_data, 64'h52);
    reset = 1'b1;
    tick();
    chk("s6_valid", 64'(bus.out_valid), 64'd0);
    chk("s6_done",  64'(bus.dump_done), 64'd0);
    chk("s6_total", 64'(bus.total_stores), 64'd0);
    chk("s6_ovf",   64'(bus.overflow), 64'd0);
    reset = 1'b0;
    run_table("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_write_trace.md
Name: dm_write_trace

Overview:
- Downstream observer of the processor's data-memory write port (DM_writeEnable/DM_addr/DM_writeData) and of the dump request.
- Records every data-memory store, in program order, into an internal FIFO.
- When dump is asserted, stops capturing and drains the recorded stores over a valid/ready stream, so a bench or host can check final memory side effects.

Parameters:
N, 64, data and address width; matches the processor datapath.
DEPTH, 16, trace FIFO entries; must be a power of 2, at least 2.
CW, 32, width of the total-store counter.

Ports:
CLOCK_50  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
DM_writeEnable  in  1  data-memory write strobe from processor.
DM_addr  in  N  data-memory byte address of the store.
DM_writeData  in  N  store data.
dump  in  1  level request to stop capture and drain the trace.
out_valid  out  1  head trace entry is presented.
out_ready  in  1  consumer accepts the entry.
out_addr  out  N  address of the head entry.
out_data  out  N  data of the head entry.
out_seq  out  CW  capture sequence number of the head entry, 0-based.
overflow  out  1  sticky: at least one store was dropped because the FIFO was full.
total_stores  out  CW  count of all stores seen in CAPTURE, including dropped ones.
dump_done  out  1  sticky: drain complete.

Behaviour:
- Reset values:
  - state = CAPTURE.
  - FIFO empty; read and write pointers = 0.
  - out_valid = 0, overflow = 0, total_stores = 0, dump_done = 0.
  - out_addr, out_data, out_seq = 0.
- Reset has priority over every other input and is honoured in any state, including mid-drain.
- Entry format: {addr, data, seq}. seq is the value of total_stores at capture time.
- FSM states: CAPTURE, DRAIN, DONE.
- CAPTURE:
  - Each cycle with DM_writeEnable = 1:
    - total_stores increments, wrapping modulo 2^CW.
    - If the FIFO is not full, push the entry.
    - If the FIFO is full, drop the new store (the oldest entries are kept) and set overflow.
  - When dump = 1 at an edge, the store sampled at that same edge is still captured, then the state goes to DRAIN.
  - out_valid = 0 throughout CAPTURE.
- DRAIN:
  - DM_writeEnable is ignored; total_stores and overflow are frozen.
  - out_valid = 1 whenever the FIFO is non-empty.
  - out_addr, out_data and out_seq show the head entry: show-ahead, driven from storage registers and stable while out_valid = 1 and out_ready = 0.
  - Pop on an edge where out_valid = 1 and out_ready = 1.
  - When the FIFO is empty at an edge (including an empty FIFO on DRAIN entry), the state goes to DONE. The last pop and the transition may be one edge apart; out_valid must never be high for an empty FIFO.
- DONE:
  - dump_done = 1 and out_valid = 0.
  - Inputs are ignored; dump deasserting does not return to CAPTURE. Only reset leaves DONE.
- Latency:
  - The first out_valid rises in the cycle immediately after the edge that sampled dump = 1.
  - With out_ready held at 1, one entry is delivered per cycle.
- Full/empty:
  - Track occupancy with a count of width clog2(DEPTH)+1.
  - Full means count == DEPTH; pointers wrap modulo DEPTH.
  - No simultaneous push and pop is possible, because capture and drain are exclusive states.
- dump held high for many cycles: same as a single-cycle assertion. dump is level-sampled only in CAPTURE.
- out_addr, out_data and out_seq are don't-care when out_valid = 0, but must not be X after reset.

Test Plan:
1. Reset, then 3 stores at (0x00,0x11), (0x08,0x22), (0x10,0x33), dump = 1, out_ready = 1 -> out_valid high for 3 consecutive cycles starting the cycle after dump was sampled; entries come out in order with seq 0, 1, 2; dump_done = 1 next; total_stores = 3; overflow = 0.
2. DEPTH = 16, 20 stores with data = i for i = 0..19, then dump -> 16 entries with data 0..15; overflow = 1; total_stores = 20.
3. dump with no prior stores -> out_valid never rises; dump_done = 1 within 2 cycles; total_stores = 0.
4. During DRAIN of 4 entries, out_ready toggles 1,0,0,1,1,0,1 and DM_writeEnable = 1 every cycle -> head stays stable while out_ready = 0; exactly 4 entries are delivered in order; total_stores is unchanged.
5. Store captured on the same edge that samples dump (addr 0x18, data 0xAB) -> it is the last drained entry.
6. reset after 2 of 5 entries have drained -> next cycle out_valid = 0, dump_done = 0, total_stores = 0, overflow = 0; a new store/dump sequence then behaves as in scenario 1.
